median3x3_ctrl: RTL and testbench
=================================

# median3x3_ctrl

Sequencing controller for the 3x3 median filter in the VIP grayscale path. It takes the per-frame pixel stream, keeps two line buffers, builds a 3x3 window and drives a three-level tree of `sort_3` sorters. It re-times the frame sync signals to match the sorter latency and applies the per-frame enable/bypass setting. It sits between the gray conversion stage and the downstream binarization/edge stages.

## Interface
- `IMG_WIDTH`, default 640: active pixels per line; line buffer depth.
- `IMG_HEIGHT`, default 480: active lines per frame; row counter saturation point.
- `clk`, in, 1: pixel clock; the block's single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `median_en`, in, 1: filter enable request; sampled only at frame start.
- `per_frame_vsync`, in, 1: input frame sync, active high during vertical blanking.
- `per_frame_href`, in, 1: input line-valid.
- `per_frame_clken`, in, 1: input pixel strobe, one pixel per high cycle.
- `per_img_gray`, in, 8: input pixel.
- `post_frame_vsync`, out, 1: `per_frame_vsync` delayed by 4 clk.
- `post_frame_href`, out, 1: `per_frame_href` delayed by 4 clk.
- `post_frame_clken`, out, 1: output pixel strobe.
- `post_img_gray`, out, 8: filtered or bypassed pixel.
- `frame_active`, out, 1: high while the FSM is in ACTIVE.

## Operation
- **FSM states:** IDLE and ACTIVE.
- **Reset:** enters IDLE.
- **IDLE -> ACTIVE:** on a rising edge of `per_frame_vsync`. At this edge `median_en` is latched into `en_q`, `row` is cleared and `col` is cleared.
- **ACTIVE -> ACTIVE:** on every later vsync rising edge, with the same re-latch and clear. `en_q` is never changed mid-frame.
- **Output gating:** in IDLE, `post_frame_clken` is forced 0 and `post_img_gray` is forced 0. The delayed vsync and href still propagate.
- **`col` counter:** increments on each clken. It saturates at `IMG_WIDTH`. It clears on the href falling edge.
- **`row` counter:** increments on the href falling edge. It saturates at `IMG_HEIGHT`.
- **Line buffers:** two RAMs (`lb1`, `lb2`), each `IMG_WIDTH` x 8.
  - On clken with `col < IMG_WIDTH`: read `lb1[col]` as row r-1 and `lb2[col]` as row r-2.
  - In the same cycle, write `lb2[col] <= lb1[col]` and `lb1[col] <= per_img_gray`.
  - With `col >= IMG_WIDTH`: no write; the window is fed zeros.
- **Window:** a 3x3 register array that shifts left by one column on each clken only. Its new column is {r-2, r-1, r}.
- **Sort tree** (each `sort_3` adds 1 cycle):
  - Level 1: three instances sort the rows.
  - Level 2: three instances produce max(mins), mid(mids) and min(maxs).
  - Level 3: one instance sorts those three values; its mid output is the median.
- **Output value:**
  - `en_q=1` and `row>=2` and `col>=2`: the median. This is the window centred at (row-1, col-1).
  - `en_q=1` on the border (`row<2` or `col<2`): 0.
  - `en_q=0`: the input pixel delayed 4 clk (bypass).
  - `col` and `row` are the values at the input clken, carried down the pipeline.
- **Arithmetic:** all compares are unsigned 8-bit. There is no arithmetic widening.

## Timing
- **Latency:** exactly 4 clk from input to output for clken, href, vsync and pixel, in both modes. The breakdown is 1 cycle for the window register plus 3 cycles of sorter.
- **Throughput:** one pixel per clk; clken may be high every cycle.
- **Gaps in clken:** the window holds its contents. The sorters keep re-evaluating, but output is qualified by the delayed clken only.
- **Reset values:** every output is 0, `en_q=0`, `row=0`, `col=0`, and all delay registers are 0. Line buffer contents are don't-care, since border masking covers the first two rows.
- **Reset mid-frame:** outputs drop to 0 asynchronously. Output resumes 4 clk after the first clken following the next vsync rising edge.
- **Simultaneous events:** a vsync rise on the same cycle as an href fall takes priority; `row` clears and does not increment.
- **Overlong input:** lines longer than `IMG_WIDTH` emit 0 with clken still asserted. Frames taller than `IMG_HEIGHT` keep filtering with `row` saturated.

## Structure
- **Shared package `vip_pkg`:** `PIX_W=8`, the `SORT_LAT=1` constant, and `MED_PIPE_LAT=4`.
- **Sub-module `median_line_buf`:** the two line-buffer RAMs plus the read/shift-write logic. It is parameterised by `IMG_WIDTH`.
- **Sorters:** the seven `sort_3` instances are instantiated directly in this block.

## Test plan
- **Flat frame:** 8x4 frame, `median_en=1`, all pixels 50 -> outputs for `row>=2`, `col>=2` equal 50; border outputs 0; `post_frame_clken` mirrors input with 4-clk lag.
- **Impulse:** single pixel 255 at (3,4) in a field of 10 -> every output equals 10 (impulse removed).
- **Ramp:** pixel value = col*10 -> output at (row,col) with `row,col>=2` equals (col-1)*10.
- **Bypass switch:** `median_en=0` -> output is input delayed 4 clk. Raising `median_en` mid-frame changes nothing until the next vsync rise, after which filtering is active.
- **Reset mid-frame:** assert `rst_n=0` at pixel (2,3) -> all outputs 0 immediately. No `post_frame_clken` occurs until 4 clk after the first clken following the next vsync rise.
- **Overlong line and clken gaps:** line of `IMG_WIDTH+2` pixels with clken high every other cycle -> last 2 outputs are 0; other outputs are correct; no line-buffer corruption on the next line.

Source files
------------

// File: rtl/vip_pkg.sv
// Shared constants and types for the VIP grayscale pixel path.
package vip_pkg;

    localparam int PIX_W        = 8;
    localparam int SORT_LAT     = 1;
    localparam int MED_PIPE_LAT = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } med_state_e;

endpackage

// File: rtl/median_line_buf.sv
// Two-line pixel history for the 3x3 median window: asynchronous read of
// rows r-1/r-2 at the current column, shift-write of the new pixel in the same cycle.
module median_line_buf
    import vip_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int COL_W     = $clog2(IMG_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             pix_vld,
    input  logic [COL_W-1:0] col,
    input  logic [PIX_W-1:0] pix,
    output logic [PIX_W-1:0] row_m1,
    output logic [PIX_W-1:0] row_m2
);

    localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH);

    logic [PIX_W-1:0]  lb1 [IMG_WIDTH];
    logic [PIX_W-1:0]  lb2 [IMG_WIDTH];
    logic              in_range;
    logic [ADDR_W-1:0] addr;

    assign in_range = (col < COL_MAX);
    assign addr     = col[ADDR_W-1:0];

    // Past the end of the line the window sees zeros and the RAMs are left untouched.
    assign row_m1 = in_range ? lb1[addr] : '0;
    assign row_m2 = in_range ? lb2[addr] : '0;

    always_ff @(posedge clk) begin
        if (pix_vld && in_range) begin
            lb2[addr] <= lb1[addr];
            lb1[addr] <= pix;
        end
    end

endmodule

// File: rtl/sort_3.sv
// Registered three-input unsigned sorter, one cycle of latency.
module sort_3
    import vip_pkg::*;
#(
    parameter int DATA_W = PIX_W
) (
    input  logic              clk,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] mid_val,
    output logic [DATA_W-1:0] min_val
);

    logic [DATA_W-1:0] hi_ab;
    logic [DATA_W-1:0] lo_ab;
    logic [DATA_W-1:0] rest;
    logic [DATA_W-1:0] max_c;
    logic [DATA_W-1:0] mid_c;
    logic [DATA_W-1:0] min_c;

    // Order a/b first, then place c; the loser of the c compare meets lo_ab.
    always_comb begin
        hi_ab = (a > b) ? a : b;
        lo_ab = (a > b) ? b : a;
        max_c = (hi_ab > c) ? hi_ab : c;
        rest  = (hi_ab > c) ? c : hi_ab;
        min_c = (lo_ab < rest) ? lo_ab : rest;
        mid_c = (lo_ab < rest) ? rest : lo_ab;
    end

    always_ff @(posedge clk) begin
        max_val <= max_c;
        mid_val <= mid_c;
        min_val <= min_c;
    end

endmodule

// File: rtl/median3x3_ctrl.sv
// 3x3 median filter sequencer: line buffers, window, sort tree, sync re-timing
// and per-frame enable/bypass for the grayscale VIP path.
module median3x3_ctrl
    import vip_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             median_en,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic [PIX_W-1:0] per_img_gray,
    output logic             post_frame_vsync,
    output logic             post_frame_href,
    output logic             post_frame_clken,
    output logic [PIX_W-1:0] post_img_gray,
    output logic             frame_active
);

    localparam int COL_W = $clog2(IMG_WIDTH + 1);
    localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_TWO = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO = ROW_W'(2);

    med_state_e       state_q;
    med_state_e       state_d;
    logic             en_q;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             vsync_rise;
    logic             href_fall;
    logic             col_ok;
    logic             win_ok;

    logic             vsync_p0, vsync_p1, vsync_p2, vsync_p3;
    logic             href_p0,  href_p1,  href_p2,  href_p3;
    logic             vld_p0,   vld_p1,   vld_p2,   vld_p3;
    logic             en_p0,    en_p1,    en_p2,    en_p3;
    logic             ok_p0,    ok_p1,    ok_p2,    ok_p3;
    logic [PIX_W-1:0] pix_p0,   pix_p1,   pix_p2,   pix_p3;

    logic [PIX_W-1:0] row_m1;
    logic [PIX_W-1:0] row_m2;
    logic [PIX_W-1:0] win_p0 [3][3];

    logic [PIX_W-1:0] l1_max_p1 [3];
    logic [PIX_W-1:0] l1_mid_p1 [3];
    logic [PIX_W-1:0] l1_min_p1 [3];
    logic [PIX_W-1:0] l2_maxmin_p2;
    logic [PIX_W-1:0] l2_midmid_p2;
    logic [PIX_W-1:0] l2_minmax_p2;
    logic [PIX_W-1:0] med_p3;
    logic [PIX_W-1:0] unused_l2_a_mid, unused_l2_a_min;
    logic [PIX_W-1:0] unused_l2_b_max, unused_l2_b_min;
    logic [PIX_W-1:0] unused_l2_c_max, unused_l2_c_mid;
    logic [PIX_W-1:0] unused_l3_max,   unused_l3_min;

    // The p0 copies of vsync/href double as the previous-cycle values for edge detect.
    assign vsync_rise = per_frame_vsync & ~vsync_p0;
    assign href_fall  = ~per_frame_href & href_p0;
    assign col_ok     = (col < COL_MAX);
    assign win_ok     = col_ok && (col >= COL_TWO) && (row >= ROW_TWO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (vsync_rise) begin
            state_d = ST_ACTIVE;
        end
    end

    // A vsync rise wins over a coincident href fall: the row restarts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
            row  <= '0;
            col  <= '0;
        end else if (vsync_rise) begin
            en_q <= median_en;
            row  <= '0;
            col  <= '0;
        end else if (href_fall) begin
            col <= '0;
            if (row != ROW_MAX) begin
                row <= row + ROW_W'(1);
            end
        end else if (per_frame_clken && col_ok) begin
            col <= col + COL_W'(1);
        end
    end

    // Stage p0..p3: sideband delay line matching window + three sorter levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_p0 <= 1'b0; vsync_p1 <= 1'b0; vsync_p2 <= 1'b0; vsync_p3 <= 1'b0;
            href_p0  <= 1'b0; href_p1  <= 1'b0; href_p2  <= 1'b0; href_p3  <= 1'b0;
            vld_p0   <= 1'b0; vld_p1   <= 1'b0; vld_p2   <= 1'b0; vld_p3   <= 1'b0;
            en_p0    <= 1'b0; en_p1    <= 1'b0; en_p2    <= 1'b0; en_p3    <= 1'b0;
            ok_p0    <= 1'b0; ok_p1    <= 1'b0; ok_p2    <= 1'b0; ok_p3    <= 1'b0;
            pix_p0   <= '0;   pix_p1   <= '0;   pix_p2   <= '0;   pix_p3   <= '0;
        end else begin
            vsync_p0 <= per_frame_vsync; vsync_p1 <= vsync_p0; vsync_p2 <= vsync_p1; vsync_p3 <= vsync_p2;
            href_p0  <= per_frame_href;  href_p1  <= href_p0;  href_p2  <= href_p1;  href_p3  <= href_p2;
            vld_p0   <= per_frame_clken; vld_p1   <= vld_p0;   vld_p2   <= vld_p1;   vld_p3   <= vld_p2;
            en_p0    <= en_q;            en_p1    <= en_p0;    en_p2    <= en_p1;    en_p3    <= en_p2;
            ok_p0    <= win_ok;          ok_p1    <= ok_p0;    ok_p2    <= ok_p1;    ok_p3    <= ok_p2;
            pix_p0   <= per_img_gray;    pix_p1   <= pix_p0;   pix_p2   <= pix_p1;   pix_p3   <= pix_p2;
        end
    end

    median_line_buf #(
        .IMG_WIDTH (IMG_WIDTH),
        .COL_W     (COL_W)
    ) u_line_buf (
        .clk     (clk),
        .pix_vld (per_frame_clken),
        .col     (col),
        .pix     (per_img_gray),
        .row_m1  (row_m1),
        .row_m2  (row_m2)
    );

    // Stage p0: window, row 0 = line r-2, row 2 = current line, column 2 = newest.
    always_ff @(posedge clk) begin
        if (per_frame_clken) begin
            for (int r = 0; r < 3; r++) begin
                win_p0[r][0] <= win_p0[r][1];
                win_p0[r][1] <= win_p0[r][2];
            end
            win_p0[0][2] <= row_m2;
            win_p0[1][2] <= row_m1;
            win_p0[2][2] <= col_ok ? per_img_gray : '0;
        end
    end

    // Stage p1: per-row sort.
    for (genvar g = 0; g < 3; g++) begin : g_l1
        sort_3 #(.DATA_W(PIX_W)) u_sort (
            .clk     (clk),
            .a       (win_p0[g][0]),
            .b       (win_p0[g][1]),
            .c       (win_p0[g][2]),
            .max_val (l1_max_p1[g]),
            .mid_val (l1_mid_p1[g]),
            .min_val (l1_min_p1[g])
        );
    end

    // Stage p2: max of mins, mid of mids, min of maxes.
    sort_3 #(.DATA_W(PIX_W)) u_l2_mins (
        .clk     (clk),
        .a       (l1_min_p1[0]),
        .b       (l1_min_p1[1]),
        .c       (l1_min_p1[2]),
        .max_val (l2_maxmin_p2),
        .mid_val (unused_l2_a_mid),
        .min_val (unused_l2_a_min)
    );

    sort_3 #(.DATA_W(PIX_W)) u_l2_mids (
        .clk     (clk),
        .a       (l1_mid_p1[0]),
        .b       (l1_mid_p1[1]),
        .c       (l1_mid_p1[2]),
        .max_val (unused_l2_b_max),
        .mid_val (l2_midmid_p2),
        .min_val (unused_l2_b_min)
    );

    sort_3 #(.DATA_W(PIX_W)) u_l2_maxs (
        .clk     (clk),
        .a       (l1_max_p1[0]),
        .b       (l1_max_p1[1]),
        .c       (l1_max_p1[2]),
        .max_val (unused_l2_c_max),
        .mid_val (unused_l2_c_mid),
        .min_val (l2_minmax_p2)
    );

    // Stage p3: the median of the three candidates is the median of the window.
    sort_3 #(.DATA_W(PIX_W)) u_l3 (
        .clk     (clk),
        .a       (l2_maxmin_p2),
        .b       (l2_midmid_p2),
        .c       (l2_minmax_p2),
        .max_val (unused_l3_max),
        .mid_val (med_p3),
        .min_val (unused_l3_min)
    );

    always_comb begin
        post_frame_vsync = vsync_p3;
        post_frame_href  = href_p3;
        post_frame_clken = 1'b0;
        post_img_gray    = '0;
        frame_active     = (state_q == ST_ACTIVE);
        if (state_q == ST_ACTIVE) begin
            post_frame_clken = vld_p3;
            if (!en_p3) begin
                post_img_gray = pix_p3;
            end else if (ok_p3) begin
                post_img_gray = med_p3;
            end
        end
    end

endmodule

// File: tb/tb_median3x3_ctrl.sv
// Directed frame-level bench for median3x3_ctrl on an 8-pixel-wide, 4-line image.
module tb_median3x3_ctrl;

    localparam int W = 8;
    localparam int H = 4;

    logic       clk;
    logic       rst_n;
    logic       median_en;
    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic [7:0] per_img_gray;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic [7:0] post_img_gray;
    logic       frame_active;

    median3x3_ctrl #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .median_en        (median_en),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_gray     (per_img_gray),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_gray    (post_img_gray),
        .frame_active     (frame_active)
    );

    typedef struct {
        int v;
        int r;
        int c;
        int t;
    } exp_t;

    typedef struct {
        string name;
        int    pat;
        bit    en;
        bit    en_mid;
        int    lines;
        int    len;
        bit    gap;
        int    r0;
        int    c0;
        int    e0;
        int    r1;
        int    c1;
        int    e1;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   out_img [6][10];
    int   n_chk;
    int   n_err;
    int   cyc;
    int   n_out;
    bit   hist_vs [4];
    bit   hist_hr [4];
    bit   frame_on;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pix(input int pat, input int r, input int c);
        case (pat)
            0:       return 50;
            1:       return (r == 3 && c == 4) ? 255 : 10;
            2:       return c * 10;
            default: return r * 20 + c;
        endcase
    endfunction

    function automatic int median9(input int pat, input int rc, input int cc);
        int a [9];
        int k;
        int tmp;
        k = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                a[k] = pix(pat, rc + dr, cc + dc);
                k++;
            end
        end
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (a[j] > a[j+1]) begin
                    tmp = a[j]; a[j] = a[j+1]; a[j+1] = tmp;
                end
            end
        end
        return a[4];
    endfunction

    function automatic int exp_out(input int pat, input bit en, input int r, input int c);
        if (!en) return pix(pat, r, c);
        if (r < 2 || c < 2 || c >= W) return 0;
        return median9(pat, r - 1, c - 1);
    endfunction

    // Record what the DUT samples on each rising edge; history resets with the DUT.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) begin
                    hist_vs[i] = 1'b0;
                    hist_hr[i] = 1'b0;
                end
            end else begin
                for (int i = 3; i > 0; i--) begin
                    hist_vs[i] = hist_vs[i-1];
                    hist_hr[i] = hist_hr[i-1];
                end
                hist_vs[0] = per_frame_vsync;
                hist_hr[0] = per_frame_href;
            end
        end
    end

    // Output monitor on the falling edge.
    initial begin
        exp_t e;
        bit   exp_now;
        n_out = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("vsync_dly", int'(post_frame_vsync), int'(hist_vs[3]));
                chk("href_dly", int'(post_frame_href), int'(hist_hr[3]));
                while (exp_q.size() > 0 && exp_q[0].t + 3 < cyc) exp_q.delete(0);
                exp_now = (exp_q.size() > 0 && exp_q[0].t + 3 == cyc);
                chk("post_clken", int'(post_frame_clken), int'(exp_now));
                if (post_frame_clken) n_out++;
                if (exp_now) begin
                    e = exp_q.pop_front();
                    if (post_frame_clken) begin
                        chk($sformatf("pix_r%0d_c%0d", e.r, e.c), int'(post_img_gray), e.v);
                        if (e.r < 6 && e.c < 10) out_img[e.r][e.c] = int'(post_img_gray);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit vs, input bit hr, input bit ck, input int v);
        per_frame_vsync = vs;
        per_frame_href  = hr;
        per_frame_clken = ck;
        per_img_gray    = 8'(v);
    endtask

    task automatic do_reset();
        int out_before;
        #2;
        rst_n    = 1'b0;
        frame_on = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_clken", int'(post_frame_clken), 0);
        chk("rst_mid_gray", int'(post_img_gray), 0);
        chk("rst_mid_vsync", int'(post_frame_vsync), 0);
        chk("rst_mid_href", int'(post_frame_href), 0);
        chk("rst_mid_active", int'(frame_active), 0);
        out_before = n_out;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) tick();
        chk("no_clken_after_rst", n_out - out_before, 0);
    endtask

    task automatic run_frame(input vec_t v, input int rst_r, input int rst_c);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 10; c++)
                out_img[r][c] = -1;
        median_en = v.en;
        drive(1'b1, 1'b0, 1'b0, 0);
        tick();
        frame_on = 1'b1;
        chk("frame_active", int'(frame_active), 1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 0);
        tick();
        tick();
        for (int r = 0; r < v.lines; r++) begin
            if (r == 1) median_en = v.en_mid;
            for (int c = 0; c < v.len; c++) begin
                if (v.gap && c > 0) begin
                    drive(1'b0, 1'b1, 1'b0, 0);
                    tick();
                end
                drive(1'b0, 1'b1, 1'b1, pix(v.pat, r, c));
                if (frame_on) exp_q.push_back('{exp_out(v.pat, v.en, r, c), r, c, cyc + 1});
                tick();
                if (r == rst_r && c == rst_c) do_reset();
            end
            drive(1'b0, 1'b0, 1'b0, 0);
            repeat (3) tick();
        end
        repeat (8) tick();
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic run_vec(input vec_t v);
        run_frame(v, -1, -1);
        chk($sformatf("%s_a", v.name), out_img[v.r0][v.c0], v.e0);
        chk($sformatf("%s_b", v.name), out_img[v.r1][v.c1], v.e1);
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        frame_on = 1'b0;
        rst_n    = 1'b0;
        median_en = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0);

        //           name              pat en    en_mid lines len gap   r0 c0 e0   r1 c1 e1
        vecs[0] = '{"flat",            0, 1'b1, 1'b1, 4, 8,  1'b0, 2, 3, 50,  3, 1, 0};
        vecs[1] = '{"impulse",         1, 1'b1, 1'b1, 4, 8,  1'b0, 3, 5, 10,  3, 4, 10};
        vecs[2] = '{"ramp",            2, 1'b1, 1'b1, 4, 8,  1'b0, 2, 3, 20,  3, 7, 60};
        vecs[3] = '{"bypass_impulse",  1, 1'b0, 1'b0, 4, 8,  1'b0, 3, 4, 255, 0, 0, 10};
        vecs[4] = '{"bypass_switch",   2, 1'b0, 1'b1, 4, 8,  1'b0, 0, 4, 40,  3, 7, 70};
        vecs[5] = '{"after_switch",    3, 1'b1, 1'b1, 4, 8,  1'b0, 2, 2, 21,  3, 4, 43};
        vecs[6] = '{"overlong_gaps",   2, 1'b1, 1'b1, 4, 10, 1'b1, 3, 9, 0,   3, 7, 60};
        vecs[7] = '{"tall",            3, 1'b1, 1'b1, 6, 8,  1'b0, 5, 4, 83,  4, 7, 66};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_clken", int'(post_frame_clken), 0);
        chk("rst_gray", int'(post_img_gray), 0);
        chk("rst_vsync", int'(post_frame_vsync), 0);
        chk("rst_active", int'(frame_active), 0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_after_rst", int'(frame_active), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset at pixel (2,3); output stays off until the next frame starts.
        run_frame(vecs[2], 2, 3);
        chk("idle_post_rst_frame", int'(frame_active), 0);
        run_vec(vecs[2]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
